nibble_serial_add_sub_seq: RTL

Sequencer that performs wide add/subtract by time-multiplexing one 4-bit add/sub slice over NIBBLES cycles, least-significant nibble first, with carry/borrow chained through a register. It sits between a requesting controller (start/done handshake) and the shared 4-bit arithmetic slice. It widens the team's 4-bit add/subtracter to multi-word operands without replicating the datapath.

---
 rtl/nibble_serial_add_sub_seq_pkg.sv | 14 +
 rtl/nibble_add_sub_slice.sv | 29 ++
 rtl/nibble_serial_add_sub_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_sub_seq_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
// State encoding and opcode values used by the sequencer and its arithmetic slice.
package nibble_serial_add_sub_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_add_sub_slice.sv
// Combinational 4-bit add/subtract slice.
// Subtraction inverts b here; the caller supplies cin=1 on the first nibble.
module nibble_add_sub_slice
    import nibble_serial_add_sub_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3
);

    logic [3:0] w_b_eff;
    logic [3:0] w_low;
    logic [1:0] w_high;

    assign w_b_eff = (sub == OP_SUB) ? ~b : b;

    // Split at bit 3 so the carry into the MSB is available for overflow.
    assign w_low  = {1'b0, a[2:0]} + {1'b0, w_b_eff[2:0]} + {3'b000, cin};
    assign w_high = {1'b0, a[3]} + {1'b0, w_b_eff[3]} + {1'b0, w_low[3]};

    assign sum  = {w_high[0], w_low[2:0]};
    assign cout = w_high[1];
    assign c3   = w_low[3];

endmodule

// File: rtl/nibble_serial_add_sub_seq.sv
// Wide add/subtract sequencer: one 4-bit slice reused over NIBBLES cycles,
// least-significant nibble first, carry chained through r_carry.
module nibble_serial_add_sub_seq
    import nibble_serial_add_sub_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow,
    output logic                   zero
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_op;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;

    logic               w_accept;
    logic               w_last;
    logic [3:0]         w_sum;
    logic               w_cout;
    logic               w_c3;
    logic [W-1:0]       w_result_next;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_state == ST_RUN) && (r_idx == LAST_IDX);

    // Operands are shifted right each RUN cycle, so the slice always sees nibble 0.
    nibble_add_sub_slice u_slice (
        .a    (r_a[3:0]),
        .b    (r_b[3:0]),
        .sub  (r_op),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .c3   (w_c3)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case/if logic so no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (r_idx == LAST_IDX) w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_result_next = r_result;
        w_result_next[{r_idx, 2'b00} +: 4] = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_ADD;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_idx   <= '0;
            r_carry <= op;
        end else if (r_state == ST_RUN) begin
            r_a      <= r_a >> 4;
            r_b      <= r_b >> 4;
            r_result <= w_result_next;
            r_carry  <= w_cout;
            if (w_last) begin
                r_carry_out <= w_cout;
                r_overflow  <= w_c3 ^ w_cout;
                r_zero      <= (w_result_next == '0);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
